grid_cursor_ctrl: RTL and testbench

- Upstream input stage for the 16-cell colour register bank.
- Takes five raw push-buttons (up/down/left/right/select) and synchronises and debounces them.
- Moves a cursor over the square cell grid.
- On select, drives the bank's write address and write strobe. The strobe is held long enough for the bank's divided write enable (one rising edge every 64 clk cycles) to capture exactly one increment.

---
 rtl/grid_cursor_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_grid_cursor_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// grid_cursor_ctrl
// Input stage for the 16-cell colour register bank. Five raw push-buttons are
// synchronised, debounced and turned into one-cycle press pulses. The pulses
// move a cursor over a square grid of cells. A select press drives the bank's
// write address and holds the write strobe for WRITE_HOLD cycles, so the bank's
// divided write enable sees exactly one rising edge during the strobe.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   btn_up/btn_down/btn_left/btn_right/btn_sel
//              raw buttons, active-high, asynchronous to clk
//   addrW      registered write address {cur_y, cur_x}
//   RegWrite   write strobe to the bank
//   cur_x      cursor column
//   cur_y      cursor row
//   busy       high while the write strobe is being held
//
// Build option:
//   CURSOR_WRAP_EN  defined   -> cursor wraps modulo the grid size
//                   undefined -> cursor saturates at 0 and at the maximum
// -----------------------------------------------------------------------------
module grid_cursor_ctrl #(
    parameter int BIT_ADDR        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int WRITE_HOLD      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_sel,
    output logic [BIT_ADDR-1:0]   addrW,
    output logic                  RegWrite,
    output logic [BIT_ADDR/2-1:0] cur_x,
    output logic [BIT_ADDR/2-1:0] cur_y,
    output logic                  busy
);

    localparam int HALF = BIT_ADDR / 2;
    localparam int NB   = 5;
    localparam int HW   = $clog2(WRITE_HOLD + 1);
    localparam logic [HALF-1:0] POS_MAX = '1;

    // Button indices inside the pulse vector.
    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    logic [NB-1:0] w_raw;
    logic [NB-1:0] w_pulse;
    logic [1:0]    r_settle;
    logic          w_settled;

    assign w_raw     = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign w_settled = (r_settle == 2'd2);

    // Counts the two cycles the synchronisers need after reset before their
    // outputs reflect the real button levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_settle <= 2'd0;
        else if (!w_settled) r_settle <= r_settle + 2'd1;
    end

    // Per-button synchroniser, debouncer and rising-edge detector.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_btn
            logic            r_s1, r_s2, r_lvl, r_lvl_d, r_arm, r_pulse;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_d <= 1'b0;
                    r_arm   <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_raw[gi];
                    r_s2    <= r_s1;
                    r_lvl_d <= r_lvl;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                    // A button only becomes live once it has been seen released
                    // after reset, so a button held through reset never fires
                    // until it is let go and pressed again.
                    if (w_settled && !r_s2 && !r_lvl)
                        r_arm <= 1'b1;
                    r_pulse <= r_lvl & ~r_lvl_d & r_arm;
                end
            end

            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    function automatic logic [HALF-1:0] f_inc(input logic [HALF-1:0] v);
`ifdef CURSOR_WRAP_EN
        return v + HALF'(1);
`else
        return (v == POS_MAX) ? v : v + HALF'(1);
`endif
    endfunction

    function automatic logic [HALF-1:0] f_dec(input logic [HALF-1:0] v);
`ifdef CURSOR_WRAP_EN
        return v - HALF'(1);
`else
        return (v == '0) ? v : v - HALF'(1);
`endif
    endfunction

    state_t          r_state, w_state_next;
    logic [HW-1:0]   r_hold, w_hold_next;
    logic [HALF-1:0] r_cur_x, r_cur_y, w_x_next, w_y_next;
    logic [BIT_ADDR-1:0] r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_cur_x <= w_x_next;
            r_cur_y <= w_y_next;
            r_addr  <= {w_y_next, w_x_next};
        end
    end

    // Next-state and cursor logic. In IDLE only the highest-priority pulse is
    // honoured; in WRITE every pulse is ignored and the cursor is frozen.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_x_next     = r_cur_x;
        w_y_next     = r_cur_y;
        case (r_state)
            S_IDLE: begin
                if (w_pulse[B_SEL]) begin
                    w_state_next = S_WRITE;
                    w_hold_next  = '0;
                end else if (w_pulse[B_UP]) begin
                    w_y_next = f_dec(r_cur_y);
                end else if (w_pulse[B_DOWN]) begin
                    w_y_next = f_inc(r_cur_y);
                end else if (w_pulse[B_LEFT]) begin
                    w_x_next = f_dec(r_cur_x);
                end else if (w_pulse[B_RIGHT]) begin
                    w_x_next = f_inc(r_cur_x);
                end
            end
            S_WRITE: begin
                if (r_hold == HW'(WRITE_HOLD - 1)) begin
                    w_state_next = S_IDLE;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold + HW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Strobe decoded straight from the state register so an asynchronous
    // reset removes it immediately.
    assign RegWrite = (r_state == S_WRITE);
    assign busy     = (r_state == S_WRITE);
    assign addrW    = r_addr;
    assign cur_x    = r_cur_x;
    assign cur_y    = r_cur_y;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
module tb_grid_cursor_ctrl;

    localparam int DC = 4;
    localparam int WH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_sel = 1'b0;
    logic [3:0] addrW;
    logic       RegWrite;
    logic [1:0] cur_x, cur_y;
    logic       busy;

    grid_cursor_ctrl #(
        .BIT_ADDR(4), .DEBOUNCE_CYCLES(DC), .DB_W(18), .WRITE_HOLD(WH)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(b_up), .btn_down(b_down), .btn_left(b_left),
        .btn_right(b_right), .btn_sel(b_sel),
        .addrW(addrW), .RegWrite(RegWrite),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboards: expected cursor moves {y, x, addr} and expected strobes {len, addr}.
    logic [7:0] exp_pos_q[$];
    logic [7:0] exp_wr_q[$];
    int ex_x = 0, ex_y = 0;

    // Cursor monitor: every observed position change pops one expected move.
    logic [7:0] prev_pos = 8'h00;
    always @(negedge clk) begin
        logic [7:0] cur;
        logic [7:0] e;
        cur = {cur_y, cur_x, addrW};
        if (rst !== 1'b1) begin
            prev_pos = cur;
        end else if (cur !== prev_pos) begin
            total++;
            if (exp_pos_q.size() == 0) begin
                bad++;
                $display("FAIL pos_unexpected got=%h required=none", cur);
            end else begin
                e = exp_pos_q.pop_front();
                if (cur !== e) begin
                    bad++;
                    $display("FAIL pos_move got=%h required=%h", cur, e);
                end else begin
                    $display("move  x=%0d y=%0d addrW=%h", cur_x, cur_y, addrW);
                end
            end
            prev_pos = cur;
        end
    end

    // Strobe monitor: measures each RegWrite pulse and checks it on its fall.
    bit         in_wr = 0;
    int         wlen  = 0;
    logic [3:0] waddr = 4'h0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (RegWrite === 1'b1) begin
            if (!in_wr) begin
                in_wr = 1;
                wlen  = 1;
                waddr = addrW;
            end else begin
                wlen++;
                total++;
                if (addrW !== waddr) begin
                    bad++;
                    $display("FAIL wr_addr_stable got=%h required=%h", addrW, waddr);
                end
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_in_write got=%b required=1", busy);
            end
        end else begin
            if (rst === 1'b1 && busy !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL busy_idle got=%b required=0", busy);
            end
            if (in_wr) begin
                in_wr = 0;
                total++;
                if (exp_wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected len=%0d addr=%h required=none", wlen, waddr);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (wlen !== int'(e[7:4]) || waddr !== e[3:0]) begin
                        bad++;
                        $display("FAIL wr_strobe len=%0d addr=%h required len=%0d addr=%h",
                                 wlen, waddr, e[7:4], e[3:0]);
                    end else begin
                        $display("write addrW=%h len=%0d", waddr, wlen);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: b_up    = v;
            1: b_down  = v;
            2: b_left  = v;
            3: b_right = v;
            default: b_sel = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        cyc(10);
        set_btn(idx, 1'b0);
        cyc(25);
    endtask

    function automatic int m_inc(input int v);
`ifdef CURSOR_WRAP_EN
        return (v + 1) % 4;
`else
        return (v == 3) ? 3 : v + 1;
`endif
    endfunction

    function automatic int m_dec(input int v);
`ifdef CURSOR_WRAP_EN
        return (v + 3) % 4;
`else
        return (v == 0) ? 0 : v - 1;
`endif
    endfunction

    // Model a move, queue the expected result if the cursor changes, then press.
    task automatic move(input int dir);
        int nx, ny;
        logic [1:0] bx, by;
        nx = ex_x; ny = ex_y;
        case (dir)
            0: ny = m_dec(ex_y);
            1: ny = m_inc(ex_y);
            2: nx = m_dec(ex_x);
            default: nx = m_inc(ex_x);
        endcase
        bx = nx[1:0]; by = ny[1:0];
        if (nx != ex_x || ny != ex_y) exp_pos_q.push_back({by, bx, by, bx});
        ex_x = nx; ex_y = ny;
        press(dir);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        b_up = 1'b1; b_down = 1'b1; b_left = 1'b1; b_right = 1'b1; b_sel = 1'b1;
        cyc(4);
        total++; if (cur_x !== 2'd0)    begin bad++; $display("FAIL rst_cur_x got=%0d required=0", cur_x); end
        total++; if (cur_y !== 2'd0)    begin bad++; $display("FAIL rst_cur_y got=%0d required=0", cur_y); end
        total++; if (addrW !== 4'h0)    begin bad++; $display("FAIL rst_addrW got=%h required=0", addrW); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rst_RegWrite got=%b required=0", RegWrite); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
        rst = 1'b1;
        cyc(30);
        total++; if ({cur_y, cur_x, addrW} !== 8'h00) begin bad++; $display("FAIL held_no_action got=%h required=00", {cur_y, cur_x, addrW}); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL held_no_write got=%b required=0", RegWrite); end
        b_up = 1'b0; b_down = 1'b0; b_left = 1'b0; b_right = 1'b0; b_sel = 1'b0;
        cyc(25);
        $display("reset released, buttons released");
    endtask

    task automatic test_debounce;
        b_right = 1'b1;
        cyc(3);
        b_right = 1'b0;
        cyc(25);
        total++; if (cur_x !== 2'd0) begin bad++; $display("FAIL glitch_cur_x got=%0d required=0", cur_x); end
        total++; if (addrW !== 4'h0) begin bad++; $display("FAIL glitch_addrW got=%h required=0", addrW); end
        move(3);
        total++; if (cur_x !== 2'd1) begin bad++; $display("FAIL right_cur_x got=%0d required=1", cur_x); end
        total++; if (addrW !== 4'b0001) begin bad++; $display("FAIL right_addrW got=%h required=1", addrW); end
    endtask

    task automatic test_select;
        move(1);
        move(3);
        exp_wr_q.push_back({4'(WH), 4'b0110});
        b_sel = 1'b1;
        cyc(2);
        b_up = 1'b1;
        cyc(8);
        b_sel = 1'b0;
        cyc(2);
        b_up = 1'b0;
        cyc(30);
        total++; if (cur_y !== 2'd1) begin bad++; $display("FAIL sel_up_dropped got=%0d required=1", cur_y); end
        total++; if (addrW !== 4'b0110) begin bad++; $display("FAIL sel_addrW got=%h required=6", addrW); end
        total++; if (exp_wr_q.size() != 0) begin bad++; $display("FAIL sel_no_strobe pending=%0d required=0", exp_wr_q.size()); end
    endtask

    task automatic test_simultaneous;
        move(2);
        exp_wr_q.push_back({4'(WH), 4'b0101});
        b_sel = 1'b1; b_down = 1'b1;
        cyc(10);
        b_sel = 1'b0; b_down = 1'b0;
        cyc(30);
        total++; if ({cur_y, cur_x} !== 4'b0101) begin bad++; $display("FAIL simul_pos got=%h required=5", {cur_y, cur_x}); end
        total++; if (exp_wr_q.size() != 0) begin bad++; $display("FAIL simul_no_strobe pending=%0d required=0", exp_wr_q.size()); end
    endtask

    task automatic test_edges;
        logic [3:0] req;
        move(2);
        move(0);
        move(2);
        move(0);
`ifdef CURSOR_WRAP_EN
        req = 4'hF;
`else
        req = 4'h0;
`endif
        total++; if ({cur_y, cur_x} !== req) begin bad++; $display("FAIL edge_pos got=%h required=%h", {cur_y, cur_x}, req); end
        total++; if (addrW !== req) begin bad++; $display("FAIL edge_addrW got=%h required=%h", addrW, req); end
    endtask

    task automatic test_reset_mid_write;
        int n;
        logic [1:0] bx, by;
        bx = ex_x[1:0]; by = ex_y[1:0];
        exp_wr_q.push_back({4'd2, by, bx});
        b_sel = 1'b1;
        n = 0;
        while (RegWrite !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin bad++; $display("FAIL midwr_timeout waited=%0d required<50", n); end
        b_sel = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL midwr_RegWrite got=%b required=0", RegWrite); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midwr_busy got=%b required=0", busy); end
        cyc(3);
        rst = 1'b1;
        cyc(2);
        total++; if (addrW !== 4'h0) begin bad++; $display("FAIL midwr_addrW got=%h required=0", addrW); end
        total++; if ({cur_y, cur_x} !== 4'h0) begin bad++; $display("FAIL midwr_pos got=%h required=0", {cur_y, cur_x}); end
        cyc(20);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL midwr_no_resume got=%b required=0", RegWrite); end
        ex_x = 0; ex_y = 0;
        move(3);
        total++; if (addrW !== 4'h1) begin bad++; $display("FAIL post_rst_move got=%h required=1", addrW); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_select();
        test_simultaneous();
        test_edges();
        test_reset_mid_write();
        total++; if (exp_pos_q.size() != 0) begin bad++; $display("FAIL moves_pending got=%0d required=0", exp_pos_q.size()); end
        total++; if (exp_wr_q.size() != 0)  begin bad++; $display("FAIL writes_pending got=%0d required=0", exp_wr_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
